psum_sram_writer: RTL

Drains completed partial-sum rows from the output FIFO of the systolic array and writes them into a 32b x 128 output SRAM (active-low CEN/WEN, 7-bit address). It is the write-side counterpart of the corelet's SRAM read path. Each wide OFIFO row is serialized into consecutive 32-bit SRAM words starting at a programmable base address. The block sits between the ofifo and the psum SRAM port mux inside core.

---
 rtl/psum_sram_writer_if.sv | 25 ++
 rtl/psum_sram_writer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/psum_sram_writer_if.sv
// OFIFO drain port plus SRAM write port of the psum writer.
// OFIFO: the writer pops the head row by raising ofifo_rd for one cycle only while ofifo_valid=1;
// the row is taken at that edge. SRAM: a word is written on each edge where O_CEN=0 and O_WEN=0.
interface psum_sram_writer_if #(
  parameter int col     = 12,
  parameter int psum_bw = 16
);
  logic                     ofifo_valid;
  logic [col*psum_bw-1:0]   ofifo_out;
  logic                     ofifo_rd;
  logic                     O_CEN;
  logic                     O_WEN;
  logic [6:0]               O_A;
  logic [31:0]              O_D;

  modport master (
    input  ofifo_valid, ofifo_out,
    output ofifo_rd, O_CEN, O_WEN, O_A, O_D
  );

  modport slave (
    output ofifo_valid, ofifo_out,
    input  ofifo_rd, O_CEN, O_WEN, O_A, O_D
  );
endinterface

// File: rtl/psum_sram_writer.sv
// Drains partial-sum rows from the OFIFO and writes each row as consecutive
// 32-bit words (LSB word first) into the 32x128 output SRAM from a base address.
module psum_sram_writer #(
  parameter int col     = 12,
  parameter int psum_bw = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [6:0]            base_addr,
  input  logic [6:0]            num_rows,
  psum_sram_writer_if.master    bus,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [2:0]            o_state
);
  localparam int ROW_W = col * psum_bw;
  localparam int WPR   = ROW_W / 32;
  localparam int WW    = (WPR > 1) ? $clog2(WPR) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_POP   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  logic [6:0]       r_addr;
  logic [6:0]       r_rows_left;
  logic [WW-1:0]    r_word;
  logic [ROW_W-1:0] r_row;
  logic             r_ofifo_rd;
  logic             r_cen;
  logic             r_wen;
  logic [6:0]       r_a;
  logic [31:0]      r_d;
  logic             r_busy;
  logic             r_done;
  logic             r_overflow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_addr      <= 7'd0;
      r_rows_left <= 7'd0;
      r_word      <= '0;
      r_row       <= '0;
      r_ofifo_rd  <= 1'b0;
      r_cen       <= 1'b1;
      r_wen       <= 1'b1;
      r_a         <= 7'd0;
      r_d         <= 32'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_ofifo_rd <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr      <= base_addr;
            r_rows_left <= num_rows;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b1;
            if (num_rows == 7'd0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus.ofifo_valid) begin
            r_ofifo_rd <= 1'b1;
            r_state    <= S_POP;
          end
        end
        S_POP: begin
          // Word 0 goes straight to the SRAM; the rest wait in the shift register.
          r_d     <= bus.ofifo_out[31:0];
          r_row   <= bus.ofifo_out >> 32;
          r_a     <= r_addr;
          r_cen   <= 1'b0;
          r_wen   <= 1'b0;
          r_word  <= '0;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_addr <= r_addr + 7'd1;
          if (r_addr == 7'd127) r_overflow <= 1'b1;
          if (r_word == WW'(WPR - 1)) begin
            r_cen       <= 1'b1;
            r_wen       <= 1'b1;
            r_rows_left <= r_rows_left - 7'd1;
            if (r_rows_left == 7'd1) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_WAIT;
            end
          end else begin
            r_word <= r_word + WW'(1);
            r_a    <= r_addr + 7'd1;
            r_d    <= r_row[31:0];
            r_row  <= r_row >> 32;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ofifo_rd = r_ofifo_rd;
  assign bus.O_CEN    = r_cen;
  assign bus.O_WEN    = r_wen;
  assign bus.O_A      = r_a;
  assign bus.O_D      = r_d;
  assign busy         = r_busy;
  assign done         = r_done;
  assign overflow     = r_overflow;
  assign o_state      = r_state;
endmodule
